button_press_encoder: RTL and testbench
=======================================

Name: button_press_encoder

Overview:
- Converts an 8-bit amount into a timed train of clean "one" and "ten" button presses, the reverse of the press-counting debouncer path.
- Used as a stimulus source and auto-entry block. Drives the debouncer's button inputs in place of the physical buttons so that the debouncer accumulates exactly `amount`.
- Emits tens presses first, then ones presses. Each press is held long enough to pass the debounce threshold and is followed by a release gap.

Parameters:
- HOLD_CYCLES, 110, cycles each press is held high. Must exceed the debouncer MAX (100).
- GAP_CYCLES, 20, cycles of all-buttons-low between presses. Also applies after the last press.
- CNT_W, 20, width of the hold/gap timer. Must hold max(HOLD_CYCLES, GAP_CYCLES).

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- amount  input  8  value to encode (0..255); latched on accepted start
- button_one  output  1  emulated "one" button, registered
- button_ten  output  1  emulated "ten" button, registered
- busy  output  1  high in every state except IDLE
- done  output  1  single-cycle pulse when the sequence completes
- remaining  output  8  amount not yet emitted; updates at the end of each press

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-sequence):
  - state=IDLE
  - button_one=0, button_ten=0, busy=0, done=0, remaining=0, timer=0
- States: IDLE, PRESS_TEN, GAP_TEN, PRESS_ONE, GAP_ONE, FINISH.
- IDLE:
  - start=1 latches remaining<=amount. Next state depends on amount: >=10 -> PRESS_TEN; 1..9 -> PRESS_ONE; 0 -> FINISH.
  - start=0: stay in IDLE.
- PRESS_TEN:
  - button_ten=1 for exactly HOLD_CYCLES cycles, starting the cycle after entry.
  - On the last hold cycle: remaining<=remaining-10, then go to GAP_TEN.
- GAP_TEN:
  - Both buttons 0 for exactly GAP_CYCLES cycles.
  - Exit on remaining: >=10 -> PRESS_TEN; 1..9 -> PRESS_ONE; 0 -> FINISH.
- PRESS_ONE / GAP_ONE:
  - Same timing as the ten states, driving button_one; remaining decrements by 1.
  - Exit from GAP_ONE: remaining>0 -> PRESS_ONE; remaining=0 -> FINISH.
- FINISH: done=1 for exactly one cycle, busy still 1, then go to IDLE.
- Press counts: tens presses = amount/10, ones presses = amount%10.
  - Derived by repeated subtraction; no divider.
  - remaining never underflows: subtract 10 only when remaining>=10.
- Invariants:
  - button_one and button_ten are never high in the same cycle.
  - Every press is followed by a gap, so no two presses are adjacent.
- start while busy is ignored; amount changes while busy are ignored.
- Latency: the first press asserts 1 cycle after start is accepted. Total cycles from accept to done = 1 + N*(HOLD_CYCLES+GAP_CYCLES), where N = amount/10 + amount%10.
- Timer: counts 0..limit-1 and clears on every state transition.

Optional Feature:
- Macro: BUTTON_PRESS_ENCODER_ABORT_EN.
- When defined:
  - Adds input `abort` (1 bit) and output `aborted` (1 bit, reset 0).
  - abort=1 in any non-IDLE state forces, on the next edge: both buttons 0, timer=0, remaining retained, state=IDLE, busy=0, aborted=1 for one cycle.
  - done is not pulsed on abort.
  - abort in IDLE has no effect. abort has priority over start in the same cycle.
- When undefined: neither port exists, and the sequence always runs to FINISH unless reset.

Test Plan (HOLD_CYCLES=4, GAP_CYCLES=2 unless stated):
- amount=23, start pulse at cycle 0 -> button_ten high cycles 1-4 and 7-10; button_one high cycles 13-16, 19-22, 25-28; remaining 23->13->3->2->1->0; done at cycle 31.
- amount=0, start -> no button activity; busy=1 and done=1 in cycle 1; IDLE in cycle 2.
- amount=255 with default parameters -> 25 ten presses + 5 one presses, each exactly 110 high / 20 low; done after 1+30*130=3901 cycles; buttons never simultaneously high.
- start reasserted with amount=99 during an amount=12 run -> ignored; exactly 1 ten press + 2 one presses.
- reset asserted mid-hold of button_one (async, between edges) -> button_one falls immediately; busy=0 and remaining=0; the next start (amount=5) runs cleanly.
- (ABORT_EN) amount=30, abort during the second ten press -> buttons low next edge; aborted pulse; remaining=20; no done; busy=0.

Source files
------------

// File: rtl/button_press_encoder_if.sv
// Handshake/bus bundle between a requester and the button press encoder.
// The abort/aborted pair exists only when BUTTON_PRESS_ENCODER_ABORT_EN is defined.
interface button_press_encoder_if;
    logic       start;
    logic [7:0] amount;
    logic       button_one;
    logic       button_ten;
    logic       busy;
    logic       done;
    logic [7:0] remaining;
`ifdef BUTTON_PRESS_ENCODER_ABORT_EN
    logic       abort;
    logic       aborted;

    modport master (
        output start, amount, abort,
        input  button_one, button_ten, busy, done, remaining, aborted
    );
    modport slave (
        input  start, amount, abort,
        output button_one, button_ten, busy, done, remaining, aborted
    );
`else
    modport master (
        output start, amount,
        input  button_one, button_ten, busy, done, remaining
    );
    modport slave (
        input  start, amount,
        output button_one, button_ten, busy, done, remaining
    );
`endif
endinterface

// File: rtl/button_press_encoder.sv
// Encodes an 8-bit amount into timed "ten" then "one" button presses, each followed by a gap.
// Optional abort support is enabled by defining BUTTON_PRESS_ENCODER_ABORT_EN.
module button_press_encoder #(
    parameter int unsigned HOLD_CYCLES = 110,
    parameter int unsigned GAP_CYCLES  = 20,
    parameter int unsigned CNT_W       = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    button_press_encoder_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_TEN,
        GAP_TEN,
        PRESS_ONE,
        GAP_ONE,
        FINISH
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [7:0]       remaining_q, remaining_d;
    logic             button_one_q, button_one_d;
    logic             button_ten_q, button_ten_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             abort_req;

    // Tens are emitted while at least ten remain, then ones until exhausted.
    function automatic state_t route(input logic [7:0] r);
        if (r >= 8'd10)     return PRESS_TEN;
        else if (r != 8'd0) return PRESS_ONE;
        else                return FINISH;
    endfunction

`ifdef BUTTON_PRESS_ENCODER_ABORT_EN
    assign abort_req   = bus.abort;
    assign bus.aborted = aborted_q;
`else
    assign abort_req   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        aborted_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !abort_req) begin
                    remaining_d = bus.amount;
                    state_d     = route(bus.amount);
                end
            end
            PRESS_TEN: begin
                if (timer_q == HOLD_LAST) begin
                    if (remaining_q >= 8'd10) remaining_d = remaining_q - 8'd10;
                    state_d = GAP_TEN;
                end
            end
            GAP_TEN: begin
                if (timer_q == GAP_LAST) state_d = route(remaining_q);
            end
            PRESS_ONE: begin
                if (timer_q == HOLD_LAST) begin
                    if (remaining_q != 8'd0) remaining_d = remaining_q - 8'd1;
                    state_d = GAP_ONE;
                end
            end
            GAP_ONE: begin
                if (timer_q == GAP_LAST) state_d = (remaining_q != 8'd0) ? PRESS_ONE : FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && abort_req) begin
            state_d     = IDLE;
            remaining_d = remaining_q;
            aborted_d   = 1'b1;
        end

        timer_d = '0;
        if (state_d == state_q &&
            (state_q == PRESS_TEN || state_q == GAP_TEN ||
             state_q == PRESS_ONE || state_q == GAP_ONE)) begin
            timer_d = timer_q + CNT_W'(1);
        end

        // Outputs are decoded from the next state so they register together with it.
        button_ten_d = (state_d == PRESS_TEN);
        button_one_d = (state_d == PRESS_ONE);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == FINISH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            remaining_q  <= '0;
            button_one_q <= 1'b0;
            button_ten_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            remaining_q  <= remaining_d;
            button_one_q <= button_one_d;
            button_ten_q <= button_ten_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    assign bus.button_one = button_one_q;
    assign bus.button_ten = button_ten_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.remaining  = remaining_q;

endmodule

// File: tb/tb_button_press_encoder.sv
// Scoreboard bench for button_press_encoder: a short-timing instance and a default-timing instance.
// Define BUTTON_PRESS_ENCODER_ABORT_EN to also exercise the abort path.
module tb_button_press_encoder;

    typedef struct {
        int kind;   // 0 = ten press, 1 = one press, 2 = done
        int off;    // cycle offset from accept (accept cycle + 1 == 1)
        int rem;    // remaining expected right after the press ends
    } ent_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   acc   = 0;
    int   ntests = 0;
    int   nfail  = 0;
    ent_t q[$];

    button_press_encoder_if ifs ();
    button_press_encoder_if ifb ();
    virtual button_press_encoder_if vs;
    virtual button_press_encoder_if vb;

    button_press_encoder #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .CNT_W(20)) u_small (
        .clk   (clk),
        .reset (reset),
        .bus   (ifs)
    );

    button_press_encoder u_big (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_expect(input int a, input int hold, input int gap);
        int nt = a / 10;
        int no = a % 10;
        for (int i = 0; i < nt; i++) q.push_back('{0, 1 + i * (hold + gap), a - 10 * (i + 1)});
        for (int j = 0; j < no; j++) q.push_back('{1, 1 + (nt + j) * (hold + gap), no - (j + 1)});
        q.push_back('{2, 1 + (nt + no) * (hold + gap), 0});
    endtask

    task automatic mon(input virtual button_press_encoder_if vif, input int hold);
        logic pten = 1'b0;
        logic pone = 1'b0;
        int   hst  = 0;
        int   hkind = 0;
        ent_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                pten = 1'b0;
                pone = 1'b0;
                continue;
            end
`ifdef BUTTON_PRESS_ENCODER_ABORT_EN
            if (vif.aborted) begin
                pten = 1'b0;
                pone = 1'b0;
            end
`endif
            chk("exclusive", 32'(vif.button_one & vif.button_ten), 32'd0);
            if ((vif.button_ten && !pten) || (vif.button_one && !pone)) begin
                hst   = cyc;
                hkind = vif.button_ten ? 0 : 1;
            end
            if ((!vif.button_ten && pten) || (!vif.button_one && pone)) begin
                chk("hold_len", 32'(cyc - hst), 32'(hold));
                chk("press_expected", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("press_kind", 32'(hkind), 32'(e.kind));
                    chk("press_start", 32'(hst - acc + 1), 32'(e.off));
                    chk("remaining", 32'(vif.remaining), 32'(e.rem));
                end
            end
            if (vif.done) begin
                chk("done_busy", 32'(vif.busy), 32'd1);
                chk("done_expected", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("done_kind", 32'd2, 32'(e.kind));
                    chk("done_latency", 32'(cyc - acc + 1), 32'(e.off));
                end
            end
            pten = vif.button_ten;
            pone = vif.button_one;
        end
    endtask

    task automatic kick(input virtual button_press_encoder_if vif, input int a, input int hold, input int gap);
        @(negedge clk);
        vif.start  = 1'b1;
        vif.amount = 8'(a);
        push_expect(a, hold, gap);
        @(posedge clk);
        #1;
        acc = cyc;
        chk("accept_busy", 32'(vif.busy), 32'd1);
        chk("accept_remaining", 32'(vif.remaining), 32'(a));
        @(negedge clk);
        vif.start  = 1'b0;
        vif.amount = 8'($urandom_range(0, 255));
    endtask

    task automatic finish_run(input virtual button_press_encoder_if vif, input int limit);
        int got = 0;
        for (int n = 0; n < limit; n++) begin
            if (vif.done) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", 32'(got), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("idle_busy", 32'(vif.busy), 32'd0);
        chk("idle_done", 32'(vif.done), 32'd0);
        chk("queue_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int got;
        vs = ifs;
        vb = ifb;
        ifs.start = 1'b0; ifs.amount = '0;
        ifb.start = 1'b0; ifb.amount = '0;
`ifdef BUTTON_PRESS_ENCODER_ABORT_EN
        ifs.abort = 1'b0;
        ifb.abort = 1'b0;
`endif
        fork
            mon(vs, 4);
            mon(vb, 110);
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_button_one", 32'(ifs.button_one), 32'd0);
        chk("rst_button_ten", 32'(ifs.button_ten), 32'd0);
        chk("rst_busy", 32'(ifs.busy), 32'd0);
        chk("rst_done", 32'(ifs.done), 32'd0);
        chk("rst_remaining", 32'(ifs.remaining), 32'd0);
        chk("rst_big_busy", 32'(ifb.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // amount=23: two ten presses, three one presses
        kick(vs, 23, 4, 2);
        finish_run(vs, 100);

        // amount=0: straight to FINISH
        kick(vs, 0, 4, 2);
        finish_run(vs, 20);

        // start with amount=99 while an amount=12 run is busy is ignored
        kick(vs, 12, 4, 2);
        repeat (8) @(negedge clk);
        ifs.start  = 1'b1;
        ifs.amount = 8'd99;
        @(negedge clk);
        ifs.start  = 1'b0;
        finish_run(vs, 100);

        // amount=255 at default timing
        kick(vb, 255, 110, 20);
        finish_run(vb, 5000);

        // asynchronous reset in the middle of a one press
        kick(vs, 5, 4, 2);
        got = 0;
        for (int n = 0; n < 50; n++) begin
            if (ifs.button_one) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk("one_press_seen", 32'(got), 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_button_one", 32'(ifs.button_one), 32'd0);
        chk("arst_busy", 32'(ifs.busy), 32'd0);
        chk("arst_remaining", 32'(ifs.remaining), 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        kick(vs, 5, 4, 2);
        finish_run(vs, 100);

`ifdef BUTTON_PRESS_ENCODER_ABORT_EN
        // abort during the second ten press of amount=30
        kick(vs, 30, 4, 2);
        got = 0;
        for (int n = 0; n < 50; n++) begin
            if (ifs.button_ten && ifs.remaining == 8'd20) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk("second_ten_seen", 32'(got), 32'd1);
        ifs.abort = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_button_ten", 32'(ifs.button_ten), 32'd0);
        chk("abort_button_one", 32'(ifs.button_one), 32'd0);
        chk("abort_pulse", 32'(ifs.aborted), 32'd1);
        chk("abort_remaining", 32'(ifs.remaining), 32'd20);
        chk("abort_busy", 32'(ifs.busy), 32'd0);
        chk("abort_done", 32'(ifs.done), 32'd0);
        q.delete();
        @(negedge clk);
        ifs.abort = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_pulse_end", 32'(ifs.aborted), 32'd0);
        chk("abort_idle_busy", 32'(ifs.busy), 32'd0);
        chk("abort_no_done", 32'(ifs.done), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
